tone_sequencer: RTL
===================

TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001: Parameter BEAT_DIV, default 12_500_000, clock cycles per note beat (legal range 2..2^24-1).
REQ-002: Parameter GAME_LEN, default 64, notes in game tune (legal range 1..64).
REQ-003: Parameter WIN_LEN, default 32, notes in win tune (legal range 1..64).
REQ-004: Parameter LOSE_LEN, default 32, notes in lose tune (legal range 1..64).
REQ-005: clk  input  1  single system clock; all logic on rising edge.
REQ-006: rst_n  input  1  reset, synchronous, active-low.
REQ-007: state  input  2  game state: 00 idle, 01 game, 10 win, 11 lose.
REQ-008: note_addr  output  8  note ROM address, registered.
REQ-009: play  output  1  speaker enable, registered; 1 while a tune is sounding.
REQ-010: tune_sel  output  2  active tune: 00 none, 01 game, 10 win, 11 lose; registered.
REQ-011: done  output  1  one-cycle pulse when a win/lose tune finishes.

Function
REQ-012: FSM states SHALL be SILENT, GAME, WIN, LOSE, FINISHED.
REQ-013: state SHALL be registered into state_q every cycle; change = (state != state_q).
REQ-014: On change, next FSM state SHALL be SILENT/GAME/WIN/LOSE for state 00/01/10/11, with note index and beat counter cleared to 0 in the same edge.
REQ-015: Beat counter SHALL run 0..BEAT_DIV-1 in GAME/WIN/LOSE, wrap to 0, and assert internal tick when at BEAT_DIV-1; held at 0 in SILENT/FINISHED.
REQ-016: GAME: on tick, index increments; at GAME_LEN-1 it wraps to 0 (tune loops indefinitely).
REQ-017: WIN/LOSE: on tick, index increments; on tick at index LEN-1, FSM goes to FINISHED, index cleared, done pulses for exactly one cycle (the cycle after that edge).
REQ-018: FINISHED SHALL hold silent until a state change; no re-trigger while state is unchanged.
REQ-019: Change SHALL take priority over tick in the same cycle; no done pulse on a change-interrupted tune.
REQ-020: note_addr SHALL be base + index, bases: game 0, win 64, lose 128; SILENT/FINISHED output 0.
REQ-021: play SHALL be 1 in GAME/WIN/LOSE, 0 otherwise; tune_sel 01/10/11 in GAME/WIN/LOSE, 00 otherwise.
REQ-022: Outputs SHALL reflect the FSM state/index one cycle after the edge that updates them (latency state change -> new note_addr/play = 2 cycles from input transition).
REQ-023: Index and address arithmetic SHALL be unsigned, no overflow past base+LEN-1.

Reset
REQ-024: While rst_n=0 at a clock edge: FSM SILENT, state_q=00, index 0, beat counter 0, note_addr 0, play 0, tune_sel 00, done 0.
REQ-025: Reset SHALL override any event in the same cycle, including mid-tune; first cycle after reset with state!=00 is treated as a change.

Verification (BEAT_DIV=4, GAME_LEN=3, WIN_LEN=2, LOSE_LEN=2)
REQ-026: Reset, state=01 held -> play=1, tune_sel=01, note_addr sequence 0,1,2,0,1,... each held 4 cycles.
REQ-027: state 01->10 held -> note_addr 64,65 (4 cycles each), then play=0, note_addr=0, tune_sel=00, done=1 for one cycle, then stays silent.
REQ-028: state=11 held -> note_addr 128,129, then done pulse once; held state produces no second pulse.
REQ-029: state changes 10->01 on the cycle of a tick at index 1 -> no done, note_addr restarts at 0 with full 4-cycle beat.
REQ-030: rst_n=0 for one cycle mid game tune at note_addr 2 -> all outputs 0 next cycle; with state still 01 tune restarts at note_addr 0.
REQ-031: state=00 held after reset -> play=0, note_addr=0, done never asserted.

Source files
------------

// File: rtl/tone_sequencer.sv
// -----------------------------------------------------------------------------
// tone_sequencer
//
// Purpose:
//   Steps through one of three note tunes (game, win, lose) held in an
//   external note ROM. The game tune loops for as long as the game runs; the
//   win and lose tunes play once, then the sequencer falls silent and pulses
//   done. Any change on the state input restarts sequencing from the first
//   note of the newly selected tune.
//
// Parameters:
//   BEAT_DIV  clock cycles per note beat (2 .. 2^24-1)
//   GAME_LEN  notes in the game tune      (1 .. 64)
//   WIN_LEN   notes in the win tune       (1 .. 64)
//   LOSE_LEN  notes in the lose tune      (1 .. 64)
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   state      in   2  game state: 00 idle, 01 game, 10 win, 11 lose
//   note_addr  out  8  note ROM address (game 0.., win 64.., lose 128..)
//   play       out  1  speaker enable, high while a tune is sounding
//   tune_sel   out  2  active tune: 00 none, 01 game, 10 win, 11 lose
//   done       out  1  single-cycle pulse when a win/lose tune completes
// -----------------------------------------------------------------------------
module tone_sequencer #(
  parameter int BEAT_DIV = 12_500_000,
  parameter int GAME_LEN = 64,
  parameter int WIN_LEN  = 32,
  parameter int LOSE_LEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state,
  output logic [7:0] note_addr,
  output logic       play,
  output logic [1:0] tune_sel,
  output logic       done
);

  typedef enum logic [2:0] {
    SILENT   = 3'd0,
    GAME     = 3'd1,
    WIN      = 3'd2,
    LOSE     = 3'd3,
    FINISHED = 3'd4
  } fsm_t;

  localparam logic [23:0] BEAT_LAST = 24'(BEAT_DIV - 1);
  localparam logic [5:0]  GAME_LAST = 6'(GAME_LEN - 1);
  localparam logic [5:0]  WIN_LAST  = 6'(WIN_LEN - 1);
  localparam logic [5:0]  LOSE_LAST = 6'(LOSE_LEN - 1);

  localparam logic [7:0] GAME_BASE = 8'd0;
  localparam logic [7:0] WIN_BASE  = 8'd64;
  localparam logic [7:0] LOSE_BASE = 8'd128;

  fsm_t        fsm;
  logic [1:0]  state_q;
  logic [5:0]  index;
  logic [23:0] beat;

  logic        change;
  logic        sounding;
  logic        tick;
  logic        last_note;
  logic [5:0]  tune_last;
  fsm_t        target;

  // A state change is judged against the previous cycle's state, so the
  // first cycle out of reset with state != 00 restarts sequencing.
  assign change   = (state != state_q);
  assign sounding = (fsm == GAME) || (fsm == WIN) || (fsm == LOSE);
  assign tick     = sounding && (beat == BEAT_LAST);

  always_comb begin
    tune_last = GAME_LAST;
    case (fsm)
      WIN:     tune_last = WIN_LAST;
      LOSE:    tune_last = LOSE_LAST;
      default: tune_last = GAME_LAST;
    endcase
  end

  assign last_note = (index == tune_last);

  always_comb begin
    target = SILENT;
    case (state)
      2'b00:   target = SILENT;
      2'b01:   target = GAME;
      2'b10:   target = WIN;
      default: target = LOSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= SILENT;
      state_q   <= 2'b00;
      index     <= 6'd0;
      beat      <= 24'd0;
      note_addr <= 8'd0;
      play      <= 1'b0;
      tune_sel  <= 2'b00;
      done      <= 1'b0;
    end else begin
      state_q <= state;
      done    <= 1'b0;

      // Outputs follow the FSM/index as they stood before this edge, which
      // gives the two-cycle input-to-output latency.
      case (fsm)
        GAME: begin
          note_addr <= GAME_BASE + {2'b00, index};
          play      <= 1'b1;
          tune_sel  <= 2'b01;
        end
        WIN: begin
          note_addr <= WIN_BASE + {2'b00, index};
          play      <= 1'b1;
          tune_sel  <= 2'b10;
        end
        LOSE: begin
          note_addr <= LOSE_BASE + {2'b00, index};
          play      <= 1'b1;
          tune_sel  <= 2'b11;
        end
        default: begin
          note_addr <= 8'd0;
          play      <= 1'b0;
          tune_sel  <= 2'b00;
        end
      endcase

      // A change outranks a coincident tick, so an interrupted win/lose
      // tune never reports done.
      if (change) begin
        fsm   <= target;
        index <= 6'd0;
        beat  <= 24'd0;
      end else if (sounding) begin
        beat <= tick ? 24'd0 : beat + 24'd1;
        if (tick) begin
          if (last_note) begin
            index <= 6'd0;
            if (fsm != GAME) begin
              fsm  <= FINISHED;
              done <= 1'b1;
            end
          end else begin
            index <= index + 6'd1;
          end
        end
      end else begin
        // SILENT and FINISHED park here until the state input moves.
        beat  <= 24'd0;
        index <= 6'd0;
      end
    end
  end

endmodule
